// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO slot controller
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int          DATA_W          = 32;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'hC000_0000;
endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - splits a bus request into slot index, word offset and decode error
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_SLOTS      = 4,
  parameter int          SLOT_ADDR_BITS = 6,
  parameter logic [31:0] BASE_ADDR      = IO_BASE_DEFAULT,
  parameter int          IDX_W          = 2
) (
  input  logic [31:0]               addr_i,
  input  logic                      rd_i,
  input  logic                      wr_i,
  output logic [IDX_W-1:0]          idx_o,
  output logic [SLOT_ADDR_BITS-1:0] offset_o,
  output logic                      decode_err_o
);
  localparam int          LO      = SLOT_ADDR_BITS + 2 + IDX_W;
  localparam logic [31:0] UP_MASK = 32'hFFFF_FFFF << LO;

  logic [IDX_W-1:0] idx;
  logic             upper_err;
  logic             idx_err;
  logic             unused_lsb;

  assign idx       = addr_i[LO-1 -: IDX_W];
  assign offset_o  = addr_i[SLOT_ADDR_BITS+1:2];
  assign idx_o     = idx;
  assign upper_err = ((addr_i ^ BASE_ADDR) & UP_MASK) != 32'h0;
  assign idx_err   = int'({1'b0, idx}) >= NUM_SLOTS;
  // Exactly one of read/write must be requested.
  assign decode_err_o = upper_err | idx_err | (rd_i == wr_i);
  assign unused_lsb   = ^addr_i[1:0];
endmodule

// File: rtl/mmio_slot_ctrl.sv
// rtl/mmio_slot_ctrl.sv - decoded, handshaked MMIO slot controller with timeout and error counter
module mmio_slot_ctrl
  import mmio_pkg::*;
#(
  parameter int          NUM_SLOTS      = 4,
  parameter int          SLOT_ADDR_BITS = 6,
  parameter logic [31:0] BASE_ADDR      = IO_BASE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic [31:0]                 bus_addr,
  input  logic [DATA_W-1:0]           bus_wr_data,
  input  logic                        bus_cs,
  input  logic                        bus_wr,
  input  logic                        bus_rd,
  output logic [DATA_W-1:0]           bus_rd_data,
  output logic                        bus_ready,
  output logic                        bus_err,
  output logic [NUM_SLOTS-1:0]        slot_cs,
  output logic                        slot_wr,
  output logic                        slot_rd,
  output logic [SLOT_ADDR_BITS-1:0]   slot_addr,
  output logic [DATA_W-1:0]           slot_wr_data,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]        slot_ack,
  output logic [7:0]                  err_count
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [SLOT_ADDR_BITS-1:0] off_q, off_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic [7:0]                errcnt_q, errcnt_d;

  logic [IDX_W-1:0]          dec_idx;
  logic [SLOT_ADDR_BITS-1:0] dec_off;
  logic                      dec_err;
  logic                      ack_sel;
  logic [DATA_W-1:0]         rd_sel;

  // Decoding the live request lets a decode error answer in the first cycle.
  mmio_addr_decode #(
    .NUM_SLOTS      (NUM_SLOTS),
    .SLOT_ADDR_BITS (SLOT_ADDR_BITS),
    .BASE_ADDR      (BASE_ADDR),
    .IDX_W          (IDX_W)
  ) u_decode (
    .addr_i       (bus_addr),
    .rd_i         (bus_rd),
    .wr_i         (bus_wr),
    .idx_o        (dec_idx),
    .offset_o     (dec_off),
    .decode_err_o (dec_err)
  );

  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    slot_cs = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (int'({1'b0, idx_q}) == k) begin
        ack_sel    = slot_ack[k];
        rd_sel     = slot_rd_data[k*DATA_W +: DATA_W];
        slot_cs[k] = (state_q == ACCESS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: begin
        if (bus_cs) begin
          idx_d   = dec_idx;
          off_d   = dec_off;
          wdata_d = bus_wr_data;
          wr_d    = bus_wr;
          rd_d    = bus_rd;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = dec_err;
          state_d = dec_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (rd_q) rdata_d = rd_sel;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Count on entry to RESP so the new value is visible alongside bus_ready.
    if (state_q != RESP && state_d == RESP && err_d && errcnt_q != 8'hFF)
      errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus_ready    = (state_q == RESP);
  assign bus_err      = (state_q == RESP) & err_q;
  assign bus_rd_data  = rdata_q;
  assign slot_wr      = (state_q == ACCESS) & wr_q;
  assign slot_rd      = (state_q == ACCESS) & rd_q;
  assign slot_addr    = off_q;
  assign slot_wr_data = wdata_q;
  assign err_count    = errcnt_q;
endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// tb/tb_mmio_slot_ctrl.sv - directed self-checking bench for mmio_slot_ctrl
module tb_mmio_slot_ctrl;
  logic         clk;
  logic         reset_in;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wr_data;
  logic         bus_cs;
  logic         bus_wr;
  logic         bus_rd;
  logic [31:0]  bus_rd_data;
  logic         bus_ready;
  logic         bus_err;
  logic [3:0]   slot_cs;
  logic         slot_wr;
  logic         slot_rd;
  logic [5:0]   slot_addr;
  logic [31:0]  slot_wr_data;
  logic [127:0] slot_rd_data;
  logic [3:0]   slot_ack;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  mmio_slot_ctrl dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .bus_addr     (bus_addr),
    .bus_wr_data  (bus_wr_data),
    .bus_cs       (bus_cs),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_rd_data  (bus_rd_data),
    .bus_ready    (bus_ready),
    .bus_err      (bus_err),
    .slot_cs      (slot_cs),
    .slot_wr      (slot_wr),
    .slot_rd      (slot_rd),
    .slot_addr    (slot_addr),
    .slot_wr_data (slot_wr_data),
    .slot_rd_data (slot_rd_data),
    .slot_ack     (slot_ack),
    .err_count    (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic rd, input logic wr, input logic [31:0] wd);
    bus_addr    = addr;
    bus_rd      = rd;
    bus_wr      = wr;
    bus_wr_data = wd;
    bus_cs      = 1'b1;
  endtask

  task automatic release_bus();
    bus_cs = 1'b0;
    bus_rd = 1'b0;
    bus_wr = 1'b0;
  endtask

  initial begin
    reset_in     = 1'b0;
    bus_addr     = '0;
    bus_wr_data  = '0;
    bus_cs       = 1'b0;
    bus_wr       = 1'b0;
    bus_rd       = 1'b0;
    slot_ack     = '0;
    slot_rd_data = {32'hCAFE_F00D, 32'h7777_7777, 32'h5555_5555, 32'hDEAD_BEEF};
    step();
    step();
    chk("rst_slot_cs",   32'(slot_cs),     32'h0);
    chk("rst_ready",     32'(bus_ready),   32'h0);
    chk("rst_rd_data",   bus_rd_data,      32'h0);
    chk("rst_err_count", 32'(err_count),   32'h0);
    reset_in = 1'b1;
    step();

    // Write, slot 1 acks in the first ACCESS cycle.
    request(32'hC000_0104, 1'b0, 1'b1, 32'h1234_5678);
    step();
    chk("wr_slot_cs",   32'(slot_cs),   32'h2);
    chk("wr_slot_addr", 32'(slot_addr), 32'h1);
    chk("wr_slot_wr",   32'(slot_wr),   32'h1);
    chk("wr_slot_rd",   32'(slot_rd),   32'h0);
    chk("wr_wdata",     slot_wr_data,   32'h1234_5678);
    chk("wr_ready_c1",  32'(bus_ready), 32'h0);
    slot_ack = 4'b0010;
    step();
    slot_ack = '0;
    chk("wr_ready_c2", 32'(bus_ready), 32'h1);
    chk("wr_err",      32'(bus_err),   32'h0);
    chk("wr_rd_data",  bus_rd_data,    32'h0);
    chk("wr_cs_resp",  32'(slot_cs),   32'h0);
    release_bus();
    step();
    chk("wr_idle_ready", 32'(bus_ready), 32'h0);

    // Read slot 3 offset 2, ack after three wait cycles.
    request(32'hC000_0308, 1'b1, 1'b0, 32'h0);
    step();
    chk("rd_slot_cs",   32'(slot_cs),   32'h8);
    chk("rd_slot_addr", 32'(slot_addr), 32'h2);
    chk("rd_slot_rd",   32'(slot_rd),   32'h1);
    step();
    step();
    step();
    chk("rd_ready_c4", 32'(bus_ready), 32'h0);
    chk("rd_cs_c4",    32'(slot_cs),   32'h8);
    slot_ack = 4'b1000;
    step();
    slot_ack = '0;
    chk("rd_ready_c5", 32'(bus_ready), 32'h1);
    chk("rd_data",     bus_rd_data,    32'hCAFE_F00D);
    chk("rd_err",      32'(bus_err),   32'h0);
    release_bus();
    step();

    // Timeout on slot 0.
    request(32'hC000_0000, 1'b1, 1'b0, 32'h0);
    step();
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("to_cs_c%0d", i), 32'(slot_cs), 32'h1);
      chk($sformatf("to_ready_c%0d", i), 32'(bus_ready), 32'h0);
      step();
    end
    chk("to_ready_c17", 32'(bus_ready), 32'h1);
    chk("to_err",       32'(bus_err),   32'h1);
    chk("to_rd_data",   bus_rd_data,    32'h0);
    chk("to_err_count", 32'(err_count), 32'h1);
    chk("to_cs_resp",   32'(slot_cs),   32'h0);
    release_bus();
    step();

    // Decode error: outside the I/O window.
    request(32'h8000_0000, 1'b1, 1'b0, 32'h0);
    step();
    chk("dec1_ready", 32'(bus_ready), 32'h1);
    chk("dec1_err",   32'(bus_err),   32'h1);
    chk("dec1_cs",    32'(slot_cs),   32'h0);
    chk("dec1_cnt",   32'(err_count), 32'h2);
    release_bus();
    step();

    // Decode error: read and write together.
    request(32'hC000_0100, 1'b1, 1'b1, 32'h0);
    step();
    chk("dec2_ready", 32'(bus_ready), 32'h1);
    chk("dec2_err",   32'(bus_err),   32'h1);
    chk("dec2_cs",    32'(slot_cs),   32'h0);
    chk("dec2_cnt",   32'(err_count), 32'h3);
    release_bus();
    step();

    // Foreign ack ignored; selected ack on the last allowed cycle still succeeds.
    slot_rd_data[31:0] = 32'h1111_2222;
    request(32'hC000_0000, 1'b1, 1'b0, 32'h0);
    step();
    slot_ack = 4'b0100;
    step();
    slot_ack = '0;
    chk("fack_ready", 32'(bus_ready), 32'h0);
    chk("fack_cs",    32'(slot_cs),   32'h1);
    for (int i = 3; i <= 16; i++) step();
    chk("lack_ready_c16", 32'(bus_ready), 32'h0);
    slot_ack = 4'b0001;
    step();
    slot_ack = '0;
    chk("lack_ready", 32'(bus_ready), 32'h1);
    chk("lack_err",   32'(bus_err),   32'h0);
    chk("lack_data",  bus_rd_data,    32'h1111_2222);
    chk("lack_cnt",   32'(err_count), 32'h3);
    release_bus();
    step();

    // 300 back-to-back decode errors saturate the counter.
    request(32'h8000_0000, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) step();
    release_bus();
    step();
    step();
    chk("sat_cnt", 32'(err_count), 32'hFF);

    // Reset during ACCESS clears outputs without a clock edge.
    slot_rd_data[63:32] = 32'hA5A5_5A5A;
    request(32'hC000_0100, 1'b1, 1'b0, 32'h0);
    step();
    chk("mrst_cs_before", 32'(slot_cs), 32'h2);
    #2;
    reset_in = 1'b0;
    #1;
    chk("mrst_cs",    32'(slot_cs),   32'h0);
    chk("mrst_rd",    32'(slot_rd),   32'h0);
    chk("mrst_ready", 32'(bus_ready), 32'h0);
    chk("mrst_cnt",   32'(err_count), 32'h0);
    release_bus();
    step();
    reset_in = 1'b1;
    step();
    chk("post_idle_cs", 32'(slot_cs), 32'h0);
    request(32'hC000_0100, 1'b1, 1'b0, 32'h0);
    step();
    chk("post_cs", 32'(slot_cs), 32'h2);
    slot_ack = 4'b0010;
    step();
    slot_ack = '0;
    chk("post_ready", 32'(bus_ready), 32'h1);
    chk("post_err",   32'(bus_err),   32'h0);
    chk("post_data",  bus_rd_data,    32'hA5A5_5A5A);
    release_bus();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
